// File: rtl/mem_port_arbiter.sv
// Two-client arbiter for the single LC-3b memory port.
// Client 0 is the instruction-fetch side and client 1 is the load/store side.
// Ties are resolved round-robin. The winning request is latched and replayed to
// memory until mem_resp arrives. A sticky watchdog flags slow responses.
module mem_port_arbiter #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             c0_read,
    input  logic             c0_write,
    input  logic [1:0]       c0_byte_enable,
    input  logic [WIDTH-1:0] c0_address,
    input  logic [WIDTH-1:0] c0_wdata,
    output logic             c0_resp,
    output logic [WIDTH-1:0] c0_rdata,

    input  logic             c1_read,
    input  logic             c1_write,
    input  logic [1:0]       c1_byte_enable,
    input  logic [WIDTH-1:0] c1_address,
    input  logic [WIDTH-1:0] c1_wdata,
    output logic             c1_resp,
    output logic [WIDTH-1:0] c1_rdata,

    input  logic             mem_resp,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             mem_read,
    output logic             mem_write,
    output logic [1:0]       mem_byte_enable,
    output logic [WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0] mem_wdata,

    output logic [1:0]       grant,
    output logic             timeout_err
);

    // The counter must be at least 8 bits wide and still able to hold TIMEOUT.
    localparam int unsigned CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t           state_q;
    logic             last_grant_q;     // 1: client 1 was served last
    logic             mem_read_q;
    logic             mem_write_q;
    logic [1:0]       mem_be_q;
    logic [WIDTH-1:0] mem_addr_q;
    logic [WIDTH-1:0] mem_wdata_q;
    logic [1:0]       grant_q;
    logic [CW-1:0]    wdog_cnt_q;
    logic             timeout_err_q;

    logic req0;
    logic req1;
    logic pick0;
    logic [CW-1:0] wdog_cnt_inc;

    assign req0 = c0_read | c0_write;
    assign req1 = c1_read | c1_write;
    // Client 0 wins when it is alone or when client 1 had the previous turn.
    assign pick0 = req0 & (~req1 | last_grant_q);
    assign wdog_cnt_inc = wdog_cnt_q + 1'b1;

    // Arbitration FSM: latches the winning request and holds it until mem_resp.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_be_q      <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            grant_q       <= '0;
            wdog_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick0) begin
                        state_q     <= GNT0;
                        mem_read_q  <= c0_read;
                        mem_write_q <= c0_write & ~c0_read;
                        mem_be_q    <= c0_byte_enable;
                        mem_addr_q  <= c0_address;
                        mem_wdata_q <= c0_wdata;
                        grant_q     <= 2'b01;
                    end else if (req1) begin
                        state_q     <= GNT1;
                        mem_read_q  <= c1_read;
                        mem_write_q <= c1_write & ~c1_read;
                        mem_be_q    <= c1_byte_enable;
                        mem_addr_q  <= c1_address;
                        mem_wdata_q <= c1_wdata;
                        grant_q     <= 2'b10;
                    end
                end
                GNT0, GNT1: begin
                    if (mem_resp) begin
                        state_q      <= IDLE;
                        last_grant_q <= (state_q == GNT1);
                        mem_read_q   <= 1'b0;
                        mem_write_q  <= 1'b0;
                        grant_q      <= '0;
                        wdog_cnt_q   <= '0;
                    end else if ((TIMEOUT != 0) && (wdog_cnt_q != TMO)) begin
                        wdog_cnt_q <= wdog_cnt_inc;
                        if (wdog_cnt_inc == TMO) begin
                            timeout_err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Response routing back to the owning client; read data is shared.
    always_comb begin
        c0_resp = mem_resp & (state_q == GNT0);
        c1_resp = mem_resp & (state_q == GNT1);
    end

    assign c0_rdata        = mem_rdata;
    assign c1_rdata        = mem_rdata;
    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_byte_enable = mem_be_q;
    assign mem_address     = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign grant           = grant_q;
    assign timeout_err     = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (WIDTH=16, TIMEOUT=4).
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        c0_read, c0_write, c1_read, c1_write;
    logic [1:0]  c0_byte_enable, c1_byte_enable;
    logic [15:0] c0_address, c0_wdata, c1_address, c1_wdata;
    logic        c0_resp, c1_resp;
    logic [15:0] c0_rdata, c1_rdata;
    logic        mem_resp;
    logic [15:0] mem_rdata;
    logic        mem_read, mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_address, mem_wdata;
    logic [1:0]  grant;
    logic        timeout_err;

    int checks;
    int failures;

    mem_port_arbiter #(.WIDTH(16), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .c0_read(c0_read), .c0_write(c0_write), .c0_byte_enable(c0_byte_enable),
        .c0_address(c0_address), .c0_wdata(c0_wdata), .c0_resp(c0_resp), .c0_rdata(c0_rdata),
        .c1_read(c1_read), .c1_write(c1_write), .c1_byte_enable(c1_byte_enable),
        .c1_address(c1_address), .c1_wdata(c1_wdata), .c1_resp(c1_resp), .c1_rdata(c1_rdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .grant(grant), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic all_idle_outputs(input string tag);
        check({tag, "_mem_read"}, 32'(mem_read), 32'h0);
        check({tag, "_mem_write"}, 32'(mem_write), 32'h0);
        check({tag, "_grant"}, 32'(grant), 32'h0);
        check({tag, "_c0_resp"}, 32'(c0_resp), 32'h0);
        check({tag, "_c1_resp"}, 32'(c1_resp), 32'h0);
    endtask

    initial begin
        logic [1:0] exp_g;
        checks   = 0;
        failures = 0;
        reset = 1'b1;
        c0_read = 0; c0_write = 0; c0_byte_enable = '0; c0_address = '0; c0_wdata = '0;
        c1_read = 0; c1_write = 0; c1_byte_enable = '0; c1_address = '0; c1_wdata = '0;
        mem_resp = 0; mem_rdata = '0;

        // Reset state
        step();
        all_idle_outputs("rst");
        check("rst_addr", 32'(mem_address), 32'h0);
        check("rst_tmo", 32'(timeout_err), 32'h0);
        reset = 1'b0;

        // Single read from client 0, response in third granted cycle
        c0_read = 1; c0_address = 16'h0040;
        step();
        check("rd_mem_read", 32'(mem_read), 32'h1);
        check("rd_mem_addr", 32'(mem_address), 32'h0040);
        check("rd_grant", 32'(grant), 32'h1);
        c0_read = 0;
        step();
        step();
        mem_resp = 1; mem_rdata = 16'hBEEF;
        #1;
        check("rd_c0_resp", 32'(c0_resp), 32'h1);
        check("rd_c0_rdata", 32'(c0_rdata), 32'hBEEF);
        check("rd_c1_resp", 32'(c1_resp), 32'h0);
        step();
        mem_resp = 0;
        all_idle_outputs("rd_after");

        // mem_resp while idle is ignored
        mem_resp = 1;
        #1;
        check("idle_resp_c0", 32'(c0_resp), 32'h0);
        check("idle_resp_c1", 32'(c1_resp), 32'h0);
        step();
        check("idle_resp_grant", 32'(grant), 32'h0);
        mem_resp = 0;

        // Fresh reset so client 0 wins the first tie
        reset = 1; #1; reset = 0;

        // Tie: round-robin 01,10,01,10 with one idle cycle between grants
        c0_read = 1; c0_address = 16'h0100;
        c1_write = 1; c1_address = 16'h1000; c1_wdata = 16'h1234; c1_byte_enable = 2'b11;
        exp_g = 2'b01;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr_grant", 32'(grant), 32'(exp_g));
            if (exp_g == 2'b01) begin
                check("rr_c0_rd", 32'(mem_read), 32'h1);
                check("rr_c0_addr", 32'(mem_address), 32'h0100);
            end else begin
                check("rr_c1_wr", 32'(mem_write), 32'h1);
                check("rr_c1_rd", 32'(mem_read), 32'h0);
                check("rr_c1_wdata", 32'(mem_wdata), 32'h1234);
                check("rr_c1_be", 32'(mem_byte_enable), 32'h3);
                check("rr_c1_addr", 32'(mem_address), 32'h1000);
            end
            mem_resp = 1;
            #1;
            check("rr_resp0", 32'(c0_resp), (exp_g == 2'b01) ? 32'h1 : 32'h0);
            check("rr_resp1", 32'(c1_resp), (exp_g == 2'b10) ? 32'h1 : 32'h0);
            step();
            mem_resp = 0;
            if (i == 3) begin
                c0_read = 0; c1_write = 0;
            end
            check("rr_idle_gap", 32'(grant), 32'h0);
            exp_g = (exp_g == 2'b01) ? 2'b10 : 2'b01;
        end
        step();
        check("rr_drained", 32'(grant), 32'h0);

        // Client 1 changes its request mid-grant; response after 4 granted cycles
        c1_write = 1; c1_address = 16'h2000; c1_wdata = 16'h5555; c1_byte_enable = 2'b01;
        step();
        check("chg_grant", 32'(grant), 32'h2);
        check("chg_addr0", 32'(mem_address), 32'h2000);
        c1_address = 16'h3000; c1_write = 0;
        step();
        check("chg_addr1", 32'(mem_address), 32'h2000);
        check("chg_wr1", 32'(mem_write), 32'h1);
        step();
        step();
        check("chg_addr3", 32'(mem_address), 32'h2000);
        check("chg_wr3", 32'(mem_write), 32'h1);
        check("chg_be3", 32'(mem_byte_enable), 32'h1);
        check("chg_wdata3", 32'(mem_wdata), 32'h5555);
        mem_resp = 1;
        #1;
        check("chg_c1_resp", 32'(c1_resp), 32'h1);
        check("chg_c0_resp", 32'(c0_resp), 32'h0);
        step();
        mem_resp = 0;
        check("chg_after_grant", 32'(grant), 32'h0);
        check("chg_no_tmo", 32'(timeout_err), 32'h0);

        // Read and write both set: read wins
        c0_read = 1; c0_write = 1; c0_address = 16'h0042;
        step();
        check("rw_mem_read", 32'(mem_read), 32'h1);
        check("rw_mem_write", 32'(mem_write), 32'h0);
        check("rw_grant", 32'(grant), 32'h1);
        c0_read = 0; c0_write = 0;
        mem_resp = 1;
        #1;
        check("rw_c0_resp", 32'(c0_resp), 32'h1);
        step();
        mem_resp = 0;

        // Watchdog: TIMEOUT=4, response withheld
        c1_read = 1; c1_address = 16'h0500;
        step();
        check("wd_grant", 32'(grant), 32'h2);
        c1_read = 0;
        step();
        step();
        step();
        check("wd_before", 32'(timeout_err), 32'h0);
        step();
        check("wd_rise", 32'(timeout_err), 32'h1);
        step();
        step();
        check("wd_sticky", 32'(timeout_err), 32'h1);
        check("wd_still_grant", 32'(grant), 32'h2);
        check("wd_still_read", 32'(mem_read), 32'h1);
        mem_resp = 1;
        #1;
        check("wd_late_resp", 32'(c1_resp), 32'h1);
        step();
        mem_resp = 0;
        check("wd_done_grant", 32'(grant), 32'h0);
        check("wd_after_resp", 32'(timeout_err), 32'h1);

        // Reset in the middle of a client 1 grant
        c1_read = 1; c1_address = 16'h0600;
        step();
        check("mr_grant", 32'(grant), 32'h2);
        c0_read = 1; c0_address = 16'h0700;
        #2;
        reset = 1;
        #1;
        mem_resp = 1;
        #1;
        all_idle_outputs("mr");
        check("mr_addr", 32'(mem_address), 32'h0);
        check("mr_tmo", 32'(timeout_err), 32'h0);
        mem_resp = 0;
        reset = 0;
        step();
        check("mr_first_grant", 32'(grant), 32'h1);
        check("mr_first_addr", 32'(mem_address), 32'h0700);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single LC-3b memory port between two requesters: client 0 (instruction fetch side of control/datapath) and client 1 (data load/store side). It latches one client's request, drives the memory port from internal registers until mem_resp, then returns the response to that client. Arbitration is round-robin when both clients request together. A watchdog flags memory responses that are too slow.

Parameters:
WIDTH, 16, address/data width (lc3b_word).
TIMEOUT, 255, watchdog limit in cycles; 0 disables the watchdog.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
c0_read  in  1  client 0 read request
c0_write  in  1  client 0 write request
c0_byte_enable  in  2  client 0 write mask (lc3b_mem_wmask)
c0_address  in  WIDTH  client 0 address
c0_wdata  in  WIDTH  client 0 write data
c0_resp  out  1  client 0 transaction complete
c0_rdata  out  WIDTH  client 0 read data
c1_read, c1_write, c1_byte_enable, c1_address, c1_wdata, c1_resp, c1_rdata: same as c0_* for client 1
mem_resp  in  1  memory done
mem_rdata  in  WIDTH  memory read data
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_byte_enable  out  2  memory write mask
mem_address  out  WIDTH  memory address
mem_wdata  out  WIDTH  memory write data
grant  out  2  one-hot owner of the port; 00 when idle
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. Reset forces state IDLE, all mem_* outputs to 0, grant=00, cX_resp=0, timeout_err=0, last_grant=1 (so client 0 wins the first tie), and clears the watchdog counter.
- A client requests when cX_read|cX_write. If both bits are set, the transaction is a read and the write is dropped.
- States:
  - IDLE: mem_read and mem_write are 0. At the clock edge, if exactly one client requests, latch that client's rw, address, wdata and byte_enable into the request registers and go to GNT0 or GNT1. If both request, pick the client != last_grant. No request: stay in IDLE.
  - GNTx: mem_* outputs come only from the latched registers. Client inputs are ignored, so a client that changes or drops its request mid-transaction does not affect the memory port. grant=one-hot(x).
  - GNTx with mem_resp=1: cX_resp=1 in the same cycle (combinational from mem_resp and state). At the edge, go to IDLE, set last_grant=x, clear the counter.
- Latency: a request seen at edge n drives the memory from cycle n+1. After mem_resp there is exactly one IDLE cycle before the next grant, so a client's stale request is not re-issued.
- cX_rdata = mem_rdata at all times. It is valid only while cX_resp=1.
- The non-granted client's resp stays 0. Its request stays pending and is considered in the next IDLE.
- mem_resp while in IDLE is ignored: no resp to either client, no state change.
- Watchdog (TIMEOUT>0):
  - An 8+ bit counter increments each cycle in GNTx without mem_resp and saturates at TIMEOUT.
  - When it reaches TIMEOUT, timeout_err is set and stays set until reset.
  - The arbiter keeps waiting for mem_resp (no abort).
- Reset mid-transaction: immediate return to IDLE with reset values. The in-flight transaction is abandoned and no resp is generated.

Test Plan:
- Single read: reset, then c0_read=1, c0_address=0x0040. Required: mem_read=1, mem_address=0x0040, grant=01 one cycle later. mem_resp with mem_rdata=0xBEEF after 3 cycles gives c0_resp=1 and c0_rdata=0xBEEF in that cycle. Next cycle: grant=00.
- Tie, round-robin: c0_read and c1_write (address 0x1000, wdata 0x1234, mask 11) are held continuously. Required grant order 01,10,01,10. The write cycle shows mem_write=1, mem_wdata=0x1234, mem_byte_enable=11. Each grant is separated by one idle cycle.
- Request change mid-grant: client 1 granted with address 0x2000, then changes c1_address to 0x3000 and drops c1_write. Required: mem_address stays 0x2000 and mem_write stays 1 until mem_resp.
- Read+write both set: c0_read=c0_write=1. Required: mem_read=1, mem_write=0.
- Watchdog: TIMEOUT=4, mem_resp withheld. Required: timeout_err rises after 4 granted cycles and stays 1. A later mem_resp still completes the transaction, and timeout_err stays 1 until reset.
- Reset mid-grant: assert reset while in GNT1. Required: all outputs 0 immediately without waiting for a clock edge. With both requesting after reset, client 0 is granted first.
